// File: rtl/ibex_pkg.sv
// IPM sequencer types and helpers: op codes, controller states, per-op step rules.
// Combinational helpers only; no clocked logic here.
package ibex_pkg;

  typedef enum logic [2:0] {
    IPM_OP_MUL    = 3'd0,
    IPM_OP_SQUARE = 3'd1,
    IPM_OP_HOMOG  = 3'd2,
    IPM_OP_MASK   = 3'd3,
    IPM_OP_UNMASK = 3'd4
  } ipm_op_e;

  localparam ipm_op_e IPM_OP_LAST = IPM_OP_UNMASK;

  typedef enum logic [1:0] {
    IPM_CTRL_IDLE,
    IPM_CTRL_RUN,
    IPM_CTRL_DONE,
    IPM_CTRL_ERR
  } ipm_ctrl_state_e;

  function automatic logic ipm_op_needs_rnd(ipm_op_e op);
    return (op == IPM_OP_MUL) || (op == IPM_OP_HOMOG) || (op == IPM_OP_MASK);
  endfunction

  // Share 0 is left untouched by HOMOG and MASK, so their walk starts at share 1.
  function automatic logic [2:0] ipm_op_first_idx(ipm_op_e op);
    return ((op == IPM_OP_HOMOG) || (op == IPM_OP_MASK)) ? 3'd1 : 3'd0;
  endfunction

endpackage

// File: rtl/ibex_ipm_idx_cnt.sv
// Nested share-pair counter: i outer, j inner (j only moves in mul_mode).
// Advances one step per enabled cycle; clr has priority over load, load over enable.
module ibex_ipm_idx_cnt #(
  parameter int NShares = 4,
  localparam int IdxW = $clog2(NShares)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [IdxW-1:0] load_a_i,
  input  logic            en_i,
  input  logic            mul_mode_i,
  output logic [IdxW-1:0] idx_a_o,
  output logic [IdxW-1:0] idx_b_o,
  output logic            last_o
);

  localparam logic [IdxW-1:0] MaxIdx = IdxW'(NShares - 1);

  logic [IdxW-1:0] a_q, b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
    end else if (clr_i) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load_i) begin
      a_q <= load_a_i;
      b_q <= '0;
    end else if (en_i) begin
      if (mul_mode_i && (b_q != MaxIdx)) begin
        b_q <= b_q + IdxW'(1);
      end else begin
        b_q <= '0;
        a_q <= a_q + IdxW'(1);
      end
    end
  end

  assign idx_a_o = a_q;
  assign idx_b_o = b_q;
  assign last_o  = (a_q == MaxIdx) && (!mul_mode_i || (b_q == MaxIdx));

endmodule

// File: rtl/ibex_ipm_ctrl.sv
// IPM operation sequencer: accepts one op, issues per-share steps over valid/ready,
// stalls on missing randomness or datapath backpressure; done_o S+1 cycles after accept.
module ibex_ipm_ctrl
  import ibex_pkg::*;
#(
  parameter int NShares = 4,
  localparam int IdxW = $clog2(NShares)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  output logic            ready_o,
  input  logic            kill_i,
  output logic            done_o,
  output logic            err_o,
  output logic            dp_valid_o,
  input  logic            dp_ready_i,
  output logic [2:0]      dp_op_o,
  output logic [IdxW-1:0] dp_idx_a_o,
  output logic [IdxW-1:0] dp_idx_b_o,
  output logic            dp_first_o,
  output logic            dp_last_o,
  output logic            rnd_req_o,
  input  logic            rnd_valid_i,
  output logic            busy_o
);

  ipm_ctrl_state_e state_q, state_d;
  ipm_op_e         op_q;

  logic            accept, fire, needs_rnd, is_mul, cnt_last, cnt_en, cnt_clr;
  logic [IdxW-1:0] idx_a, idx_b, first_idx;

  assign accept    = (state_q == IPM_CTRL_IDLE) && req_i && !kill_i;
  assign needs_rnd = ipm_op_needs_rnd(op_q);
  assign is_mul    = (op_q == IPM_OP_MUL);
  assign first_idx = IdxW'(ipm_op_first_idx(op_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IPM_CTRL_IDLE;
      op_q    <= IPM_OP_MUL;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= ipm_op_e'(op_i);
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    dp_valid_o = 1'b0;
    fire       = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      IPM_CTRL_IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = (op_i <= IPM_OP_LAST) ? IPM_CTRL_RUN : IPM_CTRL_ERR;
      end
      IPM_CTRL_RUN: begin
        dp_valid_o = needs_rnd ? rnd_valid_i : 1'b1;
        fire       = dp_valid_o && dp_ready_i;
        // Kill wins over a coinciding final fire so done_o can never follow a flush.
        if (kill_i) begin
          state_d = IPM_CTRL_IDLE;
          cnt_clr = 1'b1;
        end else if (fire && cnt_last) begin
          state_d = IPM_CTRL_DONE;
        end else begin
          cnt_en = fire;
        end
      end
      IPM_CTRL_DONE: begin
        done_o  = 1'b1;
        cnt_clr = 1'b1;
        state_d = IPM_CTRL_IDLE;
      end
      IPM_CTRL_ERR: begin
        err_o   = 1'b1;
        state_d = IPM_CTRL_IDLE;
      end
      default: state_d = IPM_CTRL_IDLE;
    endcase
  end

  ibex_ipm_idx_cnt #(.NShares(NShares)) u_idx_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (accept),
    .load_a_i   (IdxW'(ipm_op_first_idx(ipm_op_e'(op_i)))),
    .en_i       (cnt_en),
    .mul_mode_i (is_mul),
    .idx_a_o    (idx_a),
    .idx_b_o    (idx_b),
    .last_o     (cnt_last)
  );

  assign busy_o     = (state_q != IPM_CTRL_IDLE);
  assign rnd_req_o  = fire && needs_rnd;
  assign dp_op_o    = op_q;
  assign dp_idx_a_o = idx_a;
  assign dp_idx_b_o = idx_b;
  assign dp_first_o = is_mul ? (idx_b == '0) : (idx_a == first_idx);
  assign dp_last_o  = cnt_last;

endmodule

// File: tb/tb_ibex_ipm_ctrl.sv
// Bench for ibex_ipm_ctrl: table of directed ops plus randomized ops, each checked
// against a step list built from the per-op share-walk rules.
module tb_ibex_ipm_ctrl;

  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_i = 1'b0;
  logic [2:0]    op_i = 3'd0;
  logic          kill_i = 1'b0;
  logic          dp_ready_i = 1'b0;
  logic          rnd_valid_i = 1'b0;
  logic          ready_o, done_o, err_o, dp_valid_o, dp_first_o, dp_last_o;
  logic          rnd_req_o, busy_o;
  logic [2:0]    dp_op_o;
  logic [IW-1:0] dp_idx_a_o, dp_idx_b_o;

  ibex_ipm_ctrl #(.NShares(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .op_i(op_i), .ready_o(ready_o),
    .kill_i(kill_i), .done_o(done_o), .err_o(err_o), .dp_valid_o(dp_valid_o),
    .dp_ready_i(dp_ready_i), .dp_op_o(dp_op_o), .dp_idx_a_o(dp_idx_a_o),
    .dp_idx_b_o(dp_idx_b_o), .dp_first_o(dp_first_o), .dp_last_o(dp_last_o),
    .rnd_req_o(rnd_req_o), .rnd_valid_i(rnd_valid_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {int a; int b; bit f; bit l;} step_t;
  typedef struct {int op; int mode; int kill_at; int fires; int rnd; int done; int err;} vec_t;

  step_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit op_needs_rnd(input int op);
    return (op == 0) || (op == 2) || (op == 3);
  endfunction

  // Expected step list from the share-walk rules of each op.
  task automatic build_steps(input int op);
    step_t s;
    exp_q.delete();
    if (op == 0) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          s.a = i; s.b = j; s.f = (j == 0); s.l = (i == N-1) && (j == N-1);
          exp_q.push_back(s);
        end
    end else if (op == 1 || op == 4) begin
      for (int i = 0; i < N; i++) begin
        s.a = i; s.b = 0; s.f = (i == 0); s.l = (i == N-1);
        exp_q.push_back(s);
      end
    end else if (op == 2 || op == 3) begin
      for (int i = 1; i < N; i++) begin
        s.a = i; s.b = 0; s.f = (i == 1); s.l = (i == N-1);
        exp_q.push_back(s);
      end
    end
  endtask

  // mode 0: always ready/random; 1: random stalls; 2: rnd low 3 cycles on steps 2,3;
  // 3: dp_ready toggles every cycle. kill_at: fire index that coincides with kill (-1 none).
  task automatic run_op(input int op, input int mode, input int kill_at,
                        output int fires, output int rnds, output int dones, output int errs);
    int s, k, cyc, stall;
    bit nr, ev, ef, kl;
    build_steps(op);
    s = exp_q.size();
    nr = op_needs_rnd(op);
    fires = 0; rnds = 0; dones = 0; errs = 0;
    k = 0; cyc = 1; stall = 0; kl = 1'b0;
    @(negedge clk_i);
    check("idle_ready", ready_o, 1);
    req_i = 1'b1; op_i = op[2:0]; kill_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    if (op > 4) begin
      check("err_pulse", err_o, 1);
      check("err_no_valid", dp_valid_o, 0);
      check("err_not_ready", ready_o, 0);
      if (err_o) errs++;
      @(negedge clk_i);
      check("err_clear", err_o, 0);
      check("err_ready_back", ready_o, 1);
      return;
    end
    while (k < s && cyc < 500) begin
      case (mode)
        0: begin rnd_valid_i = 1'b1; dp_ready_i = 1'b1; end
        1: begin rnd_valid_i = ($urandom_range(0, 3) != 0); dp_ready_i = ($urandom_range(0, 3) != 0); end
        2: begin rnd_valid_i = !(k >= 1 && stall < 3); dp_ready_i = 1'b1; end
        default: begin rnd_valid_i = 1'b1; dp_ready_i = cyc[0]; end
      endcase
      kl = (k == kill_at);
      if (kl) begin rnd_valid_i = 1'b1; dp_ready_i = 1'b1; end
      kill_i = kl;
      #1;
      ev = nr ? rnd_valid_i : 1'b1;
      ef = ev && dp_ready_i;
      check("dp_valid", dp_valid_o, ev);
      check("done_early", done_o, 0);
      check("dp_op", dp_op_o, op);
      if (ev) begin
        check("idx_a", dp_idx_a_o, exp_q[k].a);
        check("idx_b", dp_idx_b_o, exp_q[k].b);
        check("first", dp_first_o, exp_q[k].f);
        check("last", dp_last_o, exp_q[k].l);
      end
      check("rnd_req", rnd_req_o, ef && nr);
      if (rnd_req_o) rnds++;
      if (ef) begin fires++; k++; stall = 0; end
      else stall++;
      @(negedge clk_i);
      cyc++;
      if (kl) break;
    end
    kill_i = 1'b0;
    if (kl) begin
      check("kill_idle", busy_o, 0);
      check("kill_no_done", done_o, 0);
      check("kill_ready", ready_o, 1);
    end else if (k == s) begin
      check("done_pulse", done_o, 1);
      check("done_no_valid", dp_valid_o, 0);
      if (done_o) dones++;
      if (mode == 0) check("latency", cyc, s + 1);
      @(negedge clk_i);
      check("done_single", done_o, 0);
      check("done_ready", ready_o, 1);
    end else begin
      check("step_timeout", k, s);
    end
  endtask

  vec_t tbl[8];

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int f, r, d, e, op, ka, s;
    tbl[0] = '{op:1, mode:0, kill_at:-1, fires:4,  rnd:0,  done:1, err:0};
    tbl[1] = '{op:0, mode:0, kill_at:-1, fires:16, rnd:16, done:1, err:0};
    tbl[2] = '{op:3, mode:2, kill_at:-1, fires:3,  rnd:3,  done:1, err:0};
    tbl[3] = '{op:4, mode:3, kill_at:-1, fires:4,  rnd:0,  done:1, err:0};
    tbl[4] = '{op:2, mode:0, kill_at:1,  fires:2,  rnd:2,  done:0, err:0};
    tbl[5] = '{op:0, mode:0, kill_at:-1, fires:16, rnd:16, done:1, err:0};
    tbl[6] = '{op:5, mode:0, kill_at:-1, fires:0,  rnd:0,  done:0, err:1};
    tbl[7] = '{op:7, mode:0, kill_at:-1, fires:0,  rnd:0,  done:0, err:1};

    #2;
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_valid", dp_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rnd_req", rnd_req_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset asserted mid-MUL must clear outputs without any clock edge.
    req_i = 1'b1; op_i = 3'd0;
    @(negedge clk_i);
    req_i = 1'b0; rnd_valid_i = 1'b1; dp_ready_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("mid_run_busy", busy_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_ready", ready_o, 1);
    check("async_rst_valid", dp_valid_o, 0);
    check("async_rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Request coinciding with kill in IDLE is dropped.
    req_i = 1'b1; kill_i = 1'b1; op_i = 3'd1;
    @(negedge clk_i);
    req_i = 1'b0; kill_i = 1'b0;
    check("idle_kill_drop", busy_o, 0);

    foreach (tbl[t]) begin
      run_op(tbl[t].op, tbl[t].mode, tbl[t].kill_at, f, r, d, e);
      check($sformatf("tbl%0d_fires", t), f, tbl[t].fires);
      check($sformatf("tbl%0d_rnd", t), r, tbl[t].rnd);
      check($sformatf("tbl%0d_done", t), d, tbl[t].done);
      check($sformatf("tbl%0d_err", t), e, tbl[t].err);
    end

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      build_steps(op);
      s = exp_q.size();
      ka = (s > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, s - 1) : -1;
      run_op(op, 1, ka, f, r, d, e);
      check("rnd_fires", f, (ka >= 0) ? ka + 1 : s);
      check("rnd_rndreq", r, op_needs_rnd(op) ? f : 0);
      check("rnd_done", d, (op <= 4 && ka < 0) ? 1 : 0);
      check("rnd_err", e, (op > 4) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_ipm_ctrl.md
Name: ibex_ipm_ctrl

Overview:
Sequencer for the inner-product-masking (IPM) datapath that executes OPCODE_IPM instructions.
- Accepts one ipm_op_e operation at a time from the EX stage.
- Breaks each operation into per-share steps, indexed by share pair (i,j), and issues them to the IPM share datapath over a valid/ready handshake.
- Gates steps on fresh randomness where required.
- Signals completion back to EX. Supports abort on pipeline flush.

Parameters:
NShares, 4, number of IPM shares n; legal range 2..8.
IdxW, $clog2(NShares), width of share indices; derived, not overridden.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous active-high reset.
req_i  in  1  EX requests an IPM operation.
op_i  in  3  ipm_op_e operation code, sampled when req_i && ready_o.
ready_o  out  1  controller idle, can accept a request.
kill_i  in  1  flush: abort current operation.
done_o  out  1  one-cycle pulse: operation complete, datapath result valid.
err_o  out  1  one-cycle pulse: illegal op code (5..7).
dp_valid_o  out  1  step command valid.
dp_ready_i  in  1  datapath accepts step.
dp_op_o  out  3  ipm_op_e of current operation.
dp_idx_a_o  out  IdxW  share index i.
dp_idx_b_o  out  IdxW  share index j (0 for non-MUL).
dp_first_o  out  1  first step of a row: datapath clears accumulator.
dp_last_o  out  1  final step of the operation.
rnd_req_o  out  1  randomness consumed this cycle.
rnd_valid_i  in  1  fresh random share available.
busy_o  out  1  state != IDLE.

Behaviour:
Reset (async, rst_i=1): state=IDLE, i=j=0, latched op=IPM_OP_MUL. Resulting outputs: ready_o=1; done_o, err_o, dp_valid_o, rnd_req_o, busy_o all 0.

States (ipm_ctrl_state_e): IDLE, RUN, DONE, ERR.
- IDLE:
  - ready_o=1.
  - On req_i && !kill_i: latch op_i. Go to RUN if op_i<=4, else ERR.
  - Load initial indices: i=1 for HOMOG and MASK, i=0 otherwise; j=0.
- RUN: per-op step sequence, n=NShares:
  - MUL: n*n steps, i outer 0..n-1, j inner 0..n-1. Each step needs randomness.
  - SQUARE: n steps, i=0..n-1, j=0. No randomness.
  - HOMOG: n-1 steps, i=1..n-1. Needs randomness.
  - MASK: n-1 steps, i=1..n-1. Needs randomness.
  - UNMASK: n steps, i=0..n-1. No randomness.
- Step outputs in RUN:
  - dp_valid_o = needs_rnd ? rnd_valid_i : 1.
  - A step fires on dp_valid_o && dp_ready_i. rnd_req_o = fire && needs_rnd.
  - dp_first_o = (j==0) for MUL; for other ops, dp_first_o=1 on the first step only.
  - dp_last_o is high on the final step. When a step with dp_last_o fires, go to DONE.
  - Indices advance only on fire. MUL: j wraps n-1→0 and i increments.
  - dp_valid_o, once asserted, drops only if rnd_valid_i drops. Index outputs are stable while dp_valid_o && !dp_ready_i.
- DONE: done_o=1 for one cycle, then IDLE. kill_i has no effect in DONE.
- ERR: err_o=1 for one cycle, then IDLE. No datapath steps are issued.
- kill_i in RUN: next state IDLE, i=j=0. kill has priority over a same-cycle fire: the datapath may see that final handshake, but done_o never pulses.
- kill_i in IDLE with req_i: the request is dropped.
- req_i while busy: ignored; ready_o=0.
- Latency: for an op with S steps and no stalls, done_o asserts S+1 cycles after the accepting edge. Back-to-back: a new req_i is accepted the cycle after DONE.

Decomposition:
- Add to ibex_pkg:
  - ipm_ctrl_state_e.
  - IPM_OP_LAST constant = IPM_OP_UNMASK.
  - Function ipm_op_needs_rnd(ipm_op_e).
  - Function ipm_op_first_idx(ipm_op_e).
- One sub-module: ibex_ipm_idx_cnt. Nested i/j counter with load, enable, mul_mode, and last-flag output, parameterised by NShares.

Test Plan:
- Reset mid-RUN (after 5 MUL steps assert rst_i) -> ready_o=1 and dp_valid_o=0 immediately, with no clock required. After release, a SQUARE completes normally.
- MUL, NShares=4, rnd_valid_i=1, dp_ready_i=1:
  - Exactly 16 fires with (i,j)=(0,0),(0,1)..(3,3).
  - dp_first_o on j=0 steps (4 pulses). dp_last_o only on (3,3). rnd_req_o 16 pulses.
  - done_o at cycle 17 after accept.
- MASK with rnd_valid_i low on steps 2 and 3 for 3 cycles each -> dp_valid_o low while stalled. Steps i=1,2,3 are issued in order with no index skip, 3 rnd_req_o pulses, done_o once.
- UNMASK with dp_ready_i toggling 0/1 every cycle -> indices held stable while not ready. 4 fires, 0 rnd_req_o, done_o after the 4th fire.
- kill_i on the same cycle as the 2nd HOMOG fire -> IDLE next cycle, no done_o. A following req_i op=MUL is accepted, starting at (0,0).
- op_i=5 and op_i=7 -> err_o one pulse each, zero dp_valid_o, ready_o back to 1 after 2 cycles.
